// File: rtl/sp_pkg.sv
// Shared types and constants for the instruction-fetch path.
package sp_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(2);

  // state | meaning
  // IDLE  | one cycle after reset before the first request
  // FETCH | request outstanding whenever the buffer has room
  // HOLD  | buffer full, waiting for decode to drain an entry
  // ERR   | ack timed out; only a redirect restarts fetch
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

  function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] pc);
    return {pc[ADDR_WIDTH-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch FIFO holding fetched instructions with their PC.
// Flush empties the buffer immediately and wins over push/pop.
module fetch_buffer
  import sp_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk_i,
  input  logic         arst_ni,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           push_ok;
  logic           pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, the imem handshake and the prefetch FIFO.
// Optional ack timeout enabled by defining FETCH_TIMEOUT_EN.
//
// state | meaning
// IDLE  | first cycle after reset, no request
// FETCH | request issued while the FIFO has room
// HOLD  | FIFO full, request withheld until an entry drains
// ERR   | ack timeout (FETCH_TIMEOUT_EN only); redirect to leave
module fetch_ctrl
  import sp_pkg::*;
#(
  parameter int                    DEPTH          = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ack_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  input  logic                  instr_ready_i,
  output logic                  fetch_err_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e          state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  fill;
  fetch_entry_t          push_data;
  fetch_entry_t          head;

  // Request depends only on registered state/count; redirect kills it in the same cycle.
  assign imem_req_o    = (state == FETCH) & ~full & ~redirect_i;
  assign imem_addr_o   = fetch_pc;
  assign push          = imem_req_o & imem_ack_i;
  assign instr_valid_o = ~empty & ~redirect_i;
  assign pop           = instr_valid_o & instr_ready_i;
  assign fill          = push & ~pop & (count == CW'(DEPTH - 1));
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;

  always_comb begin
    push_data       = '0;
    push_data.instr = imem_rdata_i;
    push_data.pc    = fetch_pc;
  end

  fetch_buffer #(
    .DEPTH(DEPTH)
  ) u_buffer (
    .clk_i    (clk_i),
    .arst_ni  (arst_ni),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .flush    (redirect_i),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          err_q;

  assign tmo_hit     = imem_req_o & ~imem_ack_i & (tmo_cnt == TW'(1));
  assign fetch_err_o = err_q;

  // Down-counter of unanswered request cycles; the error flag is sticky until reset.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      tmo_cnt <= TW'(TIMEOUT_CYCLES);
      err_q   <= 1'b0;
    end else if (redirect_i || push) begin
      tmo_cnt <= TW'(TIMEOUT_CYCLES);
    end else if (imem_req_o) begin
      if (tmo_hit) begin
        tmo_cnt <= TW'(TIMEOUT_CYCLES);
        err_q   <= 1'b1;
      end else begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end
    end
  end
`else
  assign fetch_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else if (redirect_i) begin
      state    <= FETCH;
      fetch_pc <= align_pc(redirect_pc_i);
    end else begin
      if (push) fetch_pc <= fetch_pc + PC_STEP;
      case (state)
        IDLE:  state <= FETCH;
        FETCH: begin
          if (fill) state <= HOLD;
`ifdef FETCH_TIMEOUT_EN
          else if (tmo_hit) state <= ERR;
`endif
        end
        HOLD:  if (!full) state <= FETCH;
        default: state <= state;
      endcase
    end
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencer for the instruction-fetch path.
- Owns the fetch PC and drives the imem req/ack handshake with one outstanding request.
- Buffers returned instructions with their PC in a small prefetch FIFO, and presents them to decode via a valid/ready handshake.
- Handles redirects (branch/jump) by flushing the FIFO and restarting fetch at the new PC.

Parameters:
- DEPTH, 2, prefetch FIFO entries (power of 2, ≥2).
- RESET_PC, 0, first fetch address after reset.
- TIMEOUT_CYCLES, 255, ack-wait limit (used only with FETCH_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock.
- arst_ni  in  1  reset, asynchronous, active-low.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  ADDR_WIDTH  fetch address.
- imem_ack_i  in  1  memory ack; imem_rdata_i valid this cycle.
- imem_rdata_i  in  DATA_WIDTH  fetched instruction.
- redirect_i  in  1  redirect pulse from execute.
- redirect_pc_i  in  ADDR_WIDTH  redirect target.
- instr_valid_o  out  1  FIFO head valid.
- instr_o  out  DATA_WIDTH  head instruction.
- instr_pc_o  out  ADDR_WIDTH  head PC.
- instr_ready_i  in  1  decode accepts head.
- fetch_err_o  out  1  sticky timeout error (0 if FETCH_TIMEOUT_EN is undefined).

Behaviour:
- Reset values: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0, fetch_err_o=0, FIFO empty, state IDLE.
- All regs are async-cleared.
- FSM:
  - IDLE: req=0. Next cycle go to FETCH.
  - FETCH: imem_req_o=1 while count<DEPTH. imem_addr_o=fetch_pc, held stable until ack.
    - On ack: push {imem_rdata_i, fetch_pc}; fetch_pc += 2 (mod 2^ADDR_WIDTH, wraps to 0).
    - Go to HOLD when the push makes count==DEPTH with no simultaneous pop.
  - HOLD: req=0. Go to FETCH when count<DEPTH (registered; no comb path from instr_ready_i to imem_req_o).
  - ERR (FETCH_TIMEOUT_EN only): req=0; left only via redirect or reset.
- Ack can arrive the same cycle as req (0-wait memory) or later. Ack without req is ignored.
- Steady state: one instruction per cycle with a 0-wait memory and decode always ready.
- Decode handshake:
  - instr_valid_o = (count!=0) & ~redirect_i.
  - Pop when instr_valid_o & instr_ready_i.
  - Head stays stable while valid & ~ready.
- Push and pop in the same cycle: count unchanged. Push is impossible when full because req is gated.
- Redirect (highest priority, any state):
  - Flush FIFO (count=0).
  - fetch_pc <= {redirect_pc_i[ADDR_WIDTH-1:1], 1'b0}.
  - Next state FETCH.
  - imem_req_o forced 0 that cycle; a same-cycle ack is discarded and fetch_pc does not increment.
  - A same-cycle pop is suppressed.
  - First new request appears the cycle after the redirect.
- Latency: ack at cycle N → instr_valid_o at N+1.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter counts FETCH cycles with req=1 & ~ack. It clears on ack or redirect.
  - When it reaches TIMEOUT_CYCLES, go to ERR and set fetch_err_o=1 (sticky until reset).
  - fetch_err_o is not cleared by redirect; FETCH resumes after a redirect.
- Undefined: no counter, no ERR state, fetch_err_o tied 0, and fetch waits for ack indefinitely.

Decomposition:
- sp_pkg additions:
  - fetch_state_e (IDLE, FETCH, HOLD, ERR).
  - fetch_entry_t struct {instr DATA_WIDTH, pc ADDR_WIDTH}.
  - PC_STEP=2.
- Sub-module fetch_buffer: synchronous FIFO of fetch_entry_t with push, pop, flush, count, full, empty.
- fetch_ctrl holds the FSM, fetch_pc and the timeout counter.

Test Plan:
- Reset then 0-wait memory, ready=1 → addresses 0,2,4,6 on consecutive cycles; instr_pc_o 0,2,4 one cycle after each ack; instr_o = rdata.
- Memory with 3-cycle ack latency → imem_addr_o is held for 3 cycles; only one push per ack; instr_valid_o rises 1 cycle after ack.
- ready=0 for 10 cycles → exactly DEPTH=2 entries are fetched (PCs 0,2); req=0 in HOLD. After ready=1, the entries drain in order and fetch resumes at 4.
- Redirect to 0x101 in the same cycle as an ack at PC 6 → ack data is dropped; FIFO empty next cycle; next imem_addr_o=0x100; instr_valid_o=0 during the redirect cycle.
- fetch_pc=2^ADDR_WIDTH-2 with ack → next address 0, with no glitch on instr_pc_o.
- With FETCH_TIMEOUT_EN: hold ack=0 for 255 cycles → fetch_err_o=1 and req=0. Redirect to 0x40 → fetch resumes at 0x40 with fetch_err_o still 1.
